// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings, FSM states,
// and the byte-lane helpers used for stores and loads.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is right-aligned on the bus, so replicate it across every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_WORD: res = word;
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word SRAM with per-byte write enables. Writes are synchronous; the addressed
// word is presented combinationally and registered by the responder.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port responder: accepts one load/store per handshake, waits LATENCY cycles,
// performs the SRAM access and returns extended load data with a one-cycle ready pulse.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        mem_busy
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          wr_q, wr_d;
  logic          fault_q, fault_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  logic [32:0]   offset_s;
  logic          req_s;
  logic          req_fault_s;
  logic          access_s;
  logic          sram_we_s;
  logic [31:0]   sram_rdata_s;

  // An address below BASE_ADDR wraps to a huge 33-bit offset, so one compare covers both ends.
  assign offset_s    = {1'b0, mem_addr} - BASE_EXT;
  assign req_s       = mem_read | mem_write;
  assign req_fault_s = (mem_read & mem_write)
                     | (mem_size == SZ_RSVD)
                     | ((mem_size == SZ_HALF) & mem_addr[0])
                     | ((mem_size == SZ_WORD) & (mem_addr[1:0] != 2'b00))
                     | (offset_s >= SPAN);

  assign access_s  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign sram_we_s = access_s && wr_q && !fault_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (sram_we_s),
    .be    (byte_en(size_q, off_q)),
    .addr  (idx_q),
    .wdata (lane_data(size_q, wdata_q)),
    .rdata (sram_rdata_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    wdata_d = wdata_q;
    rdata_d = 32'h00000000;
    ready_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          idx_d   = AW'(offset_s >> 2);
          off_d   = mem_addr[1:0];
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          wr_d    = mem_write;
          fault_d = req_fault_s;
          wdata_d = mem_wdata;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          error_d = fault_q;
          rdata_d = (fault_q || wr_q) ? 32'h00000000
                                      : lane_extract(sram_rdata_s, size_q, off_q, uns_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= 32'h00000000;
      rdata_q <= 32'h00000000;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_error = error_q;
  assign mem_busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 1 and 4); stimulus pushes expected responses,
// a negedge monitor pops and compares whenever mem_ready is seen.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h00000000), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_read(rd[0]),
    .mem_write(wr[0]), .mem_size(size[0]), .mem_unsigned(uns[0]), .mem_rdata(rdata[0]),
    .mem_ready(ready[0]), .mem_error(err[0]), .mem_busy(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h00000000), .LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_read(rd[1]),
    .mem_write(wr[1]), .mem_size(size[1]), .mem_unsigned(uns[1]), .mem_rdata(rdata[1]),
    .mem_ready(ready[1]), .mem_error(err[1]), .mem_busy(busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e0;
    exp_t e1;
    if (ready[0] === 1'b1) begin
      if (q0.size() == 0) begin
        chk1("spurious_ready0", ready[0], 1'b0);
      end else begin
        e0 = q0.pop_front();
        chk("rdata0", rdata[0], e0.d);
        chk1("error0", err[0], e0.e);
      end
    end
    if (ready[1] === 1'b1) begin
      if (q1.size() == 0) begin
        chk1("spurious_ready1", ready[1], 1'b0);
      end else begin
        e1 = q1.pop_front();
        chk("rdata1", rdata[1], e1.d);
        chk1("error1", err[1], e1.e);
      end
    end
  end

  task automatic push(input int d, input logic [31:0] er, input logic ee);
    exp_t x;
    x.d = er;
    x.e = ee;
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic issue(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic u,
                       input logic [31:0] er, input logic ee);
    int cyc;
    int lat;
    lat = (d == 0) ? 1 : 4;
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; rd[d] = r; wr[d] = w; size[d] = sz; uns[d] = u;
    push(d, er, ee);
    @(posedge clk); #1;
    // Scribble the bus while busy: the latched copy must be used.
    rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = ~a; wdata[d] = ~wd; size[d] = ~sz; uns[d] = ~u;
    cyc = 1;
    while (ready[d] !== 1'b1 && cyc < 40) begin
      chk1("busy_wait", busy[d], 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat + 1));
    chk1("busy_done", busy[d], 1'b1);
    @(posedge clk); #1;
    chk1("idle_ready", ready[d], 1'b0);
    chk1("idle_busy", busy[d], 1'b0);
    chk("idle_rdata", rdata[d], 32'h00000000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; addr[d] = 32'h0; wdata[d] = 32'h0; rd[d] = 1'b0; wr[d] = 1'b0;
      size[d] = 2'b00; uns[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", rdata[d], 32'h00000000);
      chk1("rst_ready", ready[d], 1'b0);
      chk1("rst_error", err[d], 1'b0);
      chk1("rst_busy", busy[d], 1'b0);
      rst[d] = 1'b0;
    end

    // Word store/load, LATENCY=1
    issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h00000000, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    // Byte/half lanes and extension
    issue(0, 1'b0, 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFF80AD, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h14, 32'h00000000, 2'b10, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h15, 32'hFFFFFF7E, 2'b00, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h16, 32'hABCD1234, 2'b01, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h14, 32'h0,        2'b10, 1'b0, 32'h12347E00, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h15, 32'h0,        2'b00, 1'b0, 32'h0000007E, 1'b0);
    // Faults
    issue(0, 1'b0, 1'b1, 32'h11,   32'h0000FFFF, 2'b01, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h12,   32'h0,        2'b10, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b1, 1'b1, 32'h10,   32'h55555555, 2'b10, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h10,   32'h0,        2'b11, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h1000, 32'h0,        2'b10, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b0, 1'b1, 32'h0,    32'h11111111, 2'b10, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h1000, 32'h22222222, 2'b10, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0,    32'h0,        2'b10, 1'b0, 32'h11111111, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h12,   32'h33333333, 2'b10, 1'b0, 32'h00000000, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
    // Top word of the range
    issue(0, 1'b0, 1'b1, 32'hFFC,  32'h5A5A5A5A, 2'b10, 1'b0, 32'h00000000, 1'b0);
    issue(0, 1'b1, 1'b0, 32'hFFC,  32'h0,        2'b10, 1'b0, 32'h5A5A5A5A, 1'b0);
    issue(0, 1'b1, 1'b0, 32'hFFF,  32'h0,        2'b00, 1'b1, 32'h0000005A, 1'b0);

    // Reset mid-WAIT aborts the store
    @(negedge clk);
    addr[0] = 32'h10; wdata[0] = 32'hCAFEF00D; wr[0] = 1'b1; size[0] = 2'b10;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    chk1("abort_busy_before", busy[0], 1'b1);
    rst[0] = 1'b1;
    #1;
    chk("abort_rdata", rdata[0], 32'h00000000);
    chk1("abort_ready", ready[0], 1'b0);
    chk1("abort_busy", busy[0], 1'b0);
    #1 rst[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk1("abort_idle_busy", busy[0], 1'b0);
      chk1("abort_idle_ready", ready[0], 1'b0);
    end
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);

    // Read held high: one ready per 3 cycles
    push(0, 32'h80ADBEEF, 1'b0); push(0, 32'h80ADBEEF, 1'b0); push(0, 32'h80ADBEEF, 1'b0);
    @(negedge clk);
    addr[0] = 32'h10; rd[0] = 1'b1; size[0] = 2'b10; uns[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (ready[0] === 1'b1) n++;
    end
    rd[0] = 1'b0;
    chk("held_read_readies", 32'(n), 32'd3);

    // LATENCY=4 path
    issue(1, 1'b0, 1'b1, 32'h20, 32'h01020304, 2'b10, 1'b0, 32'h00000000, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h01020304, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h23, 32'h0,        2'b00, 1'b0, 32'h00000001, 1'b0);

    // Write held high on LATENCY=4: one ready per 6 cycles
    push(1, 32'h00000000, 1'b0); push(1, 32'h00000000, 1'b0);
    @(negedge clk);
    addr[1] = 32'h24; wdata[1] = 32'h0A0B0C0D; wr[1] = 1'b1; size[1] = 2'b10;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (ready[1] === 1'b1) n++;
    end
    wr[1] = 1'b0;
    chk("held_write_readies", 32'(n), 32'd2);
    repeat (2) @(posedge clk);
    issue(1, 1'b1, 1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 32'h0A0B0C0D, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("q0_left", 32'(q0.size()), 32'd0);
    chk("q1_left", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
